// File: rtl/tile_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tile_map_pkg
//  Description : Shared definitions for the tile map store.
//                - Default map geometry.
//                - Depth helper function.
//                - Fill engine state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tile_map_pkg;

  localparam int COLS_DEF  = 80;
  localparam int ROWS_DEF  = 60;
  localparam int IDX_W_DEF = 6;

  // Number of map cells, one tile index per cell.
  function automatic int map_depth(input int cols, input int rows);
    return cols * rows;
  endfunction

  localparam int DEPTH_DEF  = map_depth(COLS_DEF, ROWS_DEF);
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

  // Fill engine states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

endpackage : tile_map_pkg
`default_nettype wire

// File: rtl/tile_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tile_ram
//  Description : Simple dual-port tile store.
//                - One synchronous write port.
//                - One registered read port.
//                - Read-first when both ports hit the same address on one edge.
//                - Contents are not reset.
//  Ports       : clk                         - clock
//                wr_en / wr_addr / wr_data   - write port
//                rd_en / rd_addr             - read request
//                rd_data                     - registered read data
//                                              (holds while rd_en=0)
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_ram #(
  parameter int DEPTH  = 4800,
  parameter int IDX_W  = 6,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IDX_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [IDX_W-1:0]  rd_data
);

  logic [IDX_W-1:0] r_mem [0:DEPTH-1];

  // Both accesses use non-blocking updates on the same edge, so a read of
  // the address being written returns the value held before this edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule : tile_ram
`default_nettype wire

// File: rtl/tile_map_scroll.sv
`default_nettype none
// ============================================================================
//  Module      : tile_map_scroll
//  Description : Tile map store for the video pipeline.
//                - Scrolled read path with wrap-around, 2-cycle latency.
//                - CPU write port with ready handshake.
//                - Fill engine that paints the whole map with one value.
//  Ports       : clk, rst                    - clock, async active-high reset
//                rd_en, rd_x, rd_y           - renderer read request
//                scroll_x, scroll_y          - scroll offsets (sampled with rd_en)
//                rd_valid, rd_data           - read result
//                wr_en, wr_x, wr_y, wr_data  - CPU write request
//                wr_ready                    - CPU write can be accepted
//                fill_start, fill_value      - fill request
//                fill_busy, fill_done        - fill status
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_map_scroll
  import tile_map_pkg::*;
#(
  parameter int COLS  = COLS_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int X_W   = 7,
  parameter int Y_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  // Renderer read port
  input  logic             rd_en,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  input  logic [X_W-1:0]   scroll_x,
  input  logic [Y_W-1:0]   scroll_y,
  output logic             rd_valid,
  output logic [IDX_W-1:0] rd_data,
  // CPU write port
  input  logic             wr_en,
  input  logic [X_W-1:0]   wr_x,
  input  logic [Y_W-1:0]   wr_y,
  input  logic [IDX_W-1:0] wr_data,
  output logic             wr_ready,
  // Fill engine
  input  logic             fill_start,
  input  logic [IDX_W-1:0] fill_value,
  output logic             fill_busy,
  output logic             fill_done
);

  localparam int                DEPTH     = map_depth(COLS, ROWS);
  localparam int                ADDR_W    = $clog2(DEPTH);
  // One extra bit so the limits stay representable when 2^X_W == COLS.
  localparam logic [X_W:0]      COLS_X    = (X_W+1)'(COLS);
  localparam logic [Y_W:0]      ROWS_Y    = (Y_W+1)'(ROWS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // --------------------------------------------------------------------------
  // Read address generation (combinational, registered in stage 1)
  // --------------------------------------------------------------------------
  logic [X_W:0]      w_sx;
  logic [Y_W:0]      w_sy;
  logic [X_W:0]      w_mx_sum;
  logic [Y_W:0]      w_my_sum;
  logic [X_W:0]      w_mx;
  logic [Y_W:0]      w_my;
  logic              w_rd_oob;
  logic [ADDR_W-1:0] w_rd_addr;

  always_comb begin
    // Out-of-range scroll offsets behave as no scroll.
    w_sx     = ({1'b0, scroll_x} >= COLS_X) ? '0 : {1'b0, scroll_x};
    w_sy     = ({1'b0, scroll_y} >= ROWS_Y) ? '0 : {1'b0, scroll_y};
    w_mx_sum = {1'b0, rd_x} + w_sx;
    w_my_sum = {1'b0, rd_y} + w_sy;
    // Both operands are below the limit for in-range requests, so a single
    // conditional subtract is enough to wrap.
    w_mx     = (w_mx_sum >= COLS_X) ? (w_mx_sum - COLS_X) : w_mx_sum;
    w_my     = (w_my_sum >= ROWS_Y) ? (w_my_sum - ROWS_Y) : w_my_sum;
    w_rd_oob = ({1'b0, rd_x} >= COLS_X) || ({1'b0, rd_y} >= ROWS_Y);
    w_rd_addr = ADDR_W'(w_my) * ADDR_W'(COLS) + ADDR_W'(w_mx);
  end

  // --------------------------------------------------------------------------
  // CPU write address generation (map coordinates, no scroll)
  // --------------------------------------------------------------------------
  logic              w_wr_in_range;
  logic              w_wr_accept;
  logic [ADDR_W-1:0] w_wr_addr;

  always_comb begin
    w_wr_in_range = ({1'b0, wr_x} < COLS_X) && ({1'b0, wr_y} < ROWS_Y);
    w_wr_accept   = wr_en && wr_ready;
    w_wr_addr     = ADDR_W'(wr_y) * ADDR_W'(COLS) + ADDR_W'(wr_x);
  end

  // --------------------------------------------------------------------------
  // Read pipeline
  //   stage 1: wrapped address + out-of-range flag
  //   stage 2: RAM read register; r_data_ok masks the output to zero for
  //            out-of-range requests and out of reset, since the RAM itself
  //            carries no reset.
  // --------------------------------------------------------------------------
  logic              r_s1_valid;
  logic              r_s1_oob;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_data_ok;
  logic [IDX_W-1:0]  w_ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_oob   <= 1'b0;
      r_s1_addr  <= '0;
      rd_valid   <= 1'b0;
      r_data_ok  <= 1'b0;
    end else begin
      r_s1_valid <= rd_en;
      if (rd_en) begin
        r_s1_oob  <= w_rd_oob;
        r_s1_addr <= w_rd_addr;
      end
      rd_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data_ok <= !r_s1_oob;
      end
    end
  end

  assign rd_data = r_data_ok ? w_ram_q : '0;

  // --------------------------------------------------------------------------
  // Fill FSM and write stage
  //   All RAM writes (CPU and fill) pass through one register stage so they
  //   land on the same edge as the RAM read of a request issued in the same
  //   cycle; that edge alignment is what makes same-cycle accesses read-first.
  // --------------------------------------------------------------------------
  fill_state_t       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [IDX_W-1:0]  r_fill_val;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [IDX_W-1:0]  r_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_fill_val <= '0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      wr_ready   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      fill_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          fill_busy <= 1'b0;
          wr_ready  <= 1'b1;
          // Out-of-range writes are accepted but never reach the RAM.
          if (w_wr_accept) begin
            r_wr_valid <= w_wr_in_range;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= wr_data;
          end
          if (fill_start) begin
            r_fill_val <= fill_value;
            r_cnt      <= '0;
            r_state    <= ST_FILL;
            fill_busy  <= 1'b1;
            wr_ready   <= 1'b0;
          end
        end

        ST_FILL: begin
          r_wr_valid <= 1'b1;
          r_wr_addr  <= r_cnt;
          r_wr_data  <= r_fill_val;
          if (r_cnt == LAST_ADDR) begin
            r_state   <= ST_DONE;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
            wr_ready  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          // The write port is already open again; fill_start is ignored here.
          r_cnt   <= '0;
          r_state <= ST_IDLE;
          if (w_wr_accept) begin
            r_wr_valid <= w_wr_in_range;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= wr_data;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          fill_busy <= 1'b0;
          wr_ready  <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Tile store
  // --------------------------------------------------------------------------
  tile_ram #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W)
  ) u_tile_ram (
    .clk     (clk),
    .wr_en   (r_wr_valid),
    .wr_addr (r_wr_addr),
    .wr_data (r_wr_data),
    .rd_en   (r_s1_valid),
    .rd_addr (r_s1_addr),
    .rd_data (w_ram_q)
  );

endmodule : tile_map_scroll
`default_nettype wire

// File: tb/tb_tile_map_scroll.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_map_scroll
//  Description : Directed self-checking bench for tile_map_scroll.
//                Inputs change on the falling edge, outputs are sampled on
//                the falling edge, so every sample sits half a cycle away
//                from the active rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_map_scroll;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int DEPTH = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_en = 1'b0;
  logic [6:0] rd_x = '0;
  logic [5:0] rd_y = '0;
  logic [6:0] scroll_x = '0;
  logic [5:0] scroll_y = '0;
  logic       rd_valid;
  logic [5:0] rd_data;
  logic       wr_en = 1'b0;
  logic [6:0] wr_x = '0;
  logic [5:0] wr_y = '0;
  logic [5:0] wr_data = '0;
  logic       wr_ready;
  logic       fill_start = 1'b0;
  logic [5:0] fill_value = '0;
  logic       fill_busy;
  logic       fill_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tile_map_scroll #(
    .COLS(COLS), .ROWS(ROWS), .IDX_W(6), .X_W(7), .Y_W(6)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  // ---------------------------------------------------------------- stimulus
  task automatic do_write(input logic [6:0] x, input logic [5:0] y, input logic [5:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One isolated read; v1 is rd_valid one edge after the request, v2 two edges after.
  task automatic read_cell(input logic [6:0] x, input logic [5:0] y,
                           input logic [6:0] sx, input logic [5:0] sy,
                           output logic v1, output logic v2, output logic [5:0] d);
    @(negedge clk);
    rd_en = 1'b1; rd_x = x; rd_y = y; scroll_x = sx; scroll_y = sy;
    @(negedge clk);
    rd_en = 1'b0; scroll_x = '0; scroll_y = '0;
    v1 = rd_valid;
    @(negedge clk);
    v2 = rd_valid;
    d  = rd_data;
  endtask

  // Streams back-to-back reads of linear addresses base..base+count-1 (no scroll).
  task automatic stream_read(input int base, input int count, input logic [5:0] expv,
                             output int bad, output int nvalid);
    bad = 0; nvalid = 0;
    for (int k = 0; k < count + 2; k++) begin
      @(negedge clk);
      if (k >= 2 && rd_valid) begin
        nvalid++;
        if (rd_data !== expv) bad++;
      end
      if (k < count) begin
        rd_en = 1'b1;
        rd_x  = 7'((base + k) % COLS);
        rd_y  = 6'((base + k) / COLS);
      end else begin
        rd_en = 1'b0;
      end
    end
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (rd_data !== 6'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    n_checks++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL reset_fill_busy: got %b want 0", fill_busy); end
    n_checks++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_fill_done: got %b want 0", fill_done); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_after_reset: got %b want 1", wr_ready); end
  endtask

  task automatic test_basic();
    logic v1, v2; logic [5:0] d;
    do_write(7'd5, 6'd2, 6'h2A);
    read_cell(7'd5, 6'd2, 7'd0, 6'd0, v1, v2, d);
    n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: got %b want 0", v1); end
    n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", v2); end
    n_checks++; if (d !== 6'h2A) begin n_fail++; $display("FAIL basic_data: got %h want 2a", d); end
    // Out-of-range column must not alias onto (0,1) = linear 80.
    do_write(7'd0, 6'd1, 6'h09);
    do_write(7'd80, 6'd0, 6'h15);
    read_cell(7'd0, 6'd1, 7'd0, 6'd0, v1, v2, d);
    n_checks++; if (d !== 6'h09) begin n_fail++; $display("FAIL oob_write_dropped: got %h want 09", d); end
  endtask

  task automatic test_wrap();
    logic v1, v2; logic [5:0] d;
    do_write(7'd1, 6'd0, 6'h11);
    do_write(7'd0, 6'd0, 6'h07);
    do_write(7'd78, 6'd58, 6'h33);
    read_cell(7'd79, 6'd0, 7'd2, 6'd0, v1, v2, d);
    n_checks++; if (d !== 6'h11) begin n_fail++; $display("FAIL wrap_x: got %h want 11", d); end
    read_cell(7'd0, 6'd59, 7'd0, 6'd1, v1, v2, d);
    n_checks++; if (d !== 6'h07) begin n_fail++; $display("FAIL wrap_y: got %h want 07", d); end
    // (79+79-80, 59+59-60) = (78,58)
    read_cell(7'd79, 6'd59, 7'd79, 6'd59, v1, v2, d);
    n_checks++; if (d !== 6'h33) begin n_fail++; $display("FAIL wrap_xy_max: got %h want 33", d); end
    // Scroll offsets beyond the map behave as zero.
    read_cell(7'd5, 6'd2, 7'd100, 6'd61, v1, v2, d);
    n_checks++; if (d !== 6'h2A) begin n_fail++; $display("FAIL scroll_oob_as_zero: got %h want 2a", d); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] xs [4];
    logic [5:0] exp_d [4];
    logic v1, v2; logic [5:0] d;
    xs = '{7'd10, 7'd11, 7'd12, 7'd13};
    exp_d = '{6'h01, 6'h02, 6'h03, 6'h04};
    for (int i = 0; i < 4; i++) do_write(xs[i], 6'd10, exp_d[i]);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 6) begin
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d: got %b want 1", k - 2, rd_valid); end
        n_checks++; if (rd_data !== exp_d[k-2]) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", k - 2, rd_data, exp_d[k-2]); end
      end
      if (k == 6) begin
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_end: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 6'h04) begin n_fail++; $display("FAIL b2b_data_hold: got %h want 04", rd_data); end
      end
      if (k < 4) begin rd_en = 1'b1; rd_x = xs[k]; rd_y = 6'd10; end
      else rd_en = 1'b0;
    end
    read_cell(7'd80, 6'd0, 7'd0, 6'd0, v1, v2, d);
    n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL oob_read_valid: got %b want 1", v2); end
    n_checks++; if (d !== 6'h00) begin n_fail++; $display("FAIL oob_read_data: got %h want 00", d); end
  endtask

  task automatic test_fill();
    int busy_cnt, ready_bad, done_early, cyc, bad, nvalid;
    @(negedge clk);
    fill_start = 1'b1; fill_value = 6'h3F;
    @(negedge clk);
    fill_start = 1'b0; fill_value = 6'h00;
    n_checks++; if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy_rise: got %b want 1", fill_busy); end
    busy_cnt = 1; ready_bad = 0; done_early = 0; cyc = 0;
    while (fill_busy && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (fill_busy) begin
        busy_cnt++;
        if (wr_ready !== 1'b0) ready_bad++;
        if (fill_done !== 1'b0) done_early++;
      end
      // A second fill request and a CPU write mid-fill must both be ignored.
      if (cyc == 2000) begin
        fill_start = 1'b1; fill_value = 6'h01;
        wr_en = 1'b1; wr_x = 7'd2; wr_y = 6'd2; wr_data = 6'h10;
      end else begin
        fill_start = 1'b0; fill_value = 6'h00; wr_en = 1'b0;
      end
    end
    fill_start = 1'b0; wr_en = 1'b0;
    n_checks++; if (cyc >= 6000) begin n_fail++; $display("FAIL fill_timeout: got %0d cycles want <6000", cyc); end
    n_checks++; if (busy_cnt != DEPTH) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d want %0d", busy_cnt, DEPTH); end
    n_checks++; if (ready_bad != 0) begin n_fail++; $display("FAIL fill_wr_ready_low: got %0d high cycles want 0", ready_bad); end
    n_checks++; if (done_early != 0) begin n_fail++; $display("FAIL fill_done_early: got %0d want 0", done_early); end
    n_checks++; if (fill_done !== 1'b1) begin n_fail++; $display("FAIL fill_done_pulse: got %b want 1", fill_done); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_wr_ready_back: got %b want 1", wr_ready); end
    @(negedge clk);
    n_checks++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL fill_done_width: got %b want 0", fill_done); end
    stream_read(0, DEPTH, 6'h3F, bad, nvalid);
    n_checks++; if (nvalid != DEPTH) begin n_fail++; $display("FAIL fill_read_count: got %0d want %0d", nvalid, DEPTH); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL fill_readback: got %0d wrong cells want 0", bad); end
  endtask

  task automatic test_read_first();
    logic v1, v2; logic [5:0] d;
    @(negedge clk);
    wr_en = 1'b1; wr_x = 7'd3; wr_y = 6'd3; wr_data = 6'h05;
    rd_en = 1'b1; rd_x = 7'd3; rd_y = 6'd3;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rf_valid: got %b want 1", rd_valid); end
    n_checks++; if (rd_data !== 6'h3F) begin n_fail++; $display("FAIL rf_old_value: got %h want 3f", rd_data); end
    read_cell(7'd3, 6'd3, 7'd0, 6'd0, v1, v2, d);
    n_checks++; if (d !== 6'h05) begin n_fail++; $display("FAIL rf_new_value: got %h want 05", d); end
  endtask

  task automatic test_fill_abort();
    int done_seen, bad, nvalid;
    logic v1, v2; logic [5:0] d;
    // Fill request together with a CPU write: the write goes in, then the fill starts.
    @(negedge clk);
    fill_start = 1'b1; fill_value = 6'h2C;
    wr_en = 1'b1; wr_x = 7'd7; wr_y = 6'd7; wr_data = 6'h12;
    @(negedge clk);
    fill_start = 1'b0; wr_en = 1'b0;
    n_checks++; if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_rise: got %b want 1", fill_busy); end
    // Cells 0..99 are committed to the RAM after this many edges.
    repeat (101) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_async: got %b want 0", fill_busy); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL abort_wr_ready: got %b want 0", wr_ready); end
    done_seen = 0;
    @(negedge clk);
    if (fill_done !== 1'b0) done_seen++;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (fill_done !== 1'b0) done_seen++;
    end
    n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
    n_checks++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy: got %b want 0", fill_busy); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ready: got %b want 1", wr_ready); end
    stream_read(0, 100, 6'h2C, bad, nvalid);
    n_checks++; if (bad != 0 || nvalid != 100) begin n_fail++; $display("FAIL abort_partial_fill: got %0d wrong of %0d want 0 of 100", bad, nvalid); end
    read_cell(7'd40, 6'd2, 7'd0, 6'd0, v1, v2, d);
    n_checks++; if (d !== 6'h3F) begin n_fail++; $display("FAIL abort_untouched: got %h want 3f", d); end
    read_cell(7'd7, 6'd7, 7'd0, 6'd0, v1, v2, d);
    n_checks++; if (d !== 6'h12) begin n_fail++; $display("FAIL abort_cpu_write: got %h want 12", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_fill();
    test_read_first();
    test_fill_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete within 1000000 time units");
    $fatal(1);
  end

endmodule : tb_tile_map_scroll
`default_nettype wire
